control_unit: RTL
=================

# control_unit

Instruction sequencer for the single-clock 8-bit processor. It fetches 16-bit instruction words from instruction memory over a request/valid handshake and decodes them. It then drives the datapath register file's controls: write select `select`, write enable `le`, read ports `sba`/`sbb`, ALU op, source mux and immediate `xh`. It also manages an 8-bit program counter, the zero-flag branch and halt/trap states.

## Interface
Parameters:
- `PC_RESET`, 8'h00, program counter value after reset

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `run`  in  1  level; 1 lets the FSM leave IDLE and keep fetching
- `imem_req`  out  1  fetch request
- `imem_addr`  out  8  fetch address (= `pc`)
- `imem_valid`  in  1  `imem_rdata` valid this cycle
- `imem_rdata`  in  16  instruction word
- `zero`  in  1  datapath zero flag
- `select`  out  4  destination register index
- `le`  out  1  register-file write enable, one-cycle pulse
- `sba`, `sbb`  out  4 each  read-port A/B register index
- `alu_op`  out  3  0 pass A, 1 add, 2 sub, 3 and, 4 or
- `src_sel`  out  2  write source: 0 ALU, 1 `xh`, 2 `In`
- `xh`  out  8  immediate value
- `out_le`  out  1  output-port load pulse (Out <= port A)
- `pc`  out  8  program counter
- `halted`  out  1  HALT executed
- `err`  out  1  illegal opcode trapped, sticky
- `instr_cnt`  out  16  retired-instruction count

Clocking and reset: one clock; reset is asynchronous and active-low.

## Operation
Instruction word: [15:12] opcode, [11:8] rd, [7:4] ra, [3:0] rb, [7:0] imm8.

Opcodes:
- 0 NOP
- 1 MOV rd<=ra
- 2 ADD rd<=ra+rb
- 3 SUB rd<=ra-rb
- 4 AND
- 5 OR
- 6 LDI rd<=imm8
- 7 IN rd<=In
- 8 OUT Out<=ra
- 9 JMP pc<=imm8
- A JZ (pc<=imm8 if `zero`, else pc+1)
- F HALT
- B–E illegal

Arithmetic is 8-bit modulo in the datapath. PC increments modulo 256 (0xFF -> 0x00).

FSM states and transitions:
- IDLE: `imem_req`=0. Goes to FETCH when `run`=1.
- FETCH: `imem_req`=1, `imem_addr`=pc. On a cycle with `imem_valid`=1, `imem_rdata` is captured into IR and the FSM goes to DECODE. Otherwise it stays in FETCH, with no timeout.
- DECODE: `sba`=ra and `sbb`=rb from IR. `select`, `alu_op`, `src_sel`, `xh` are driven from IR. `le`=0. Illegal opcode goes to TRAP. Otherwise goes to EXEC.
- EXEC:
  - Write ops (1–7): `le`=1 for this cycle.
  - OUT: `out_le`=1.
  - `zero` is sampled this cycle for JZ.
  - pc updates on the exit edge.
  - HALT goes to HALT_ST. Otherwise goes to FETCH if `run`=1, else IDLE.
- HALT_ST: `halted`=1, no fetch. `run` is ignored; exit only by reset.
- TRAP: `err`=1, no fetch, pc frozen at the faulting address. Exit only by reset.

Boundary and signal rules:
- `select`/`sba`/`sbb`/`alu_op`/`src_sel`/`xh` are IR-derived and stable from DECODE through EXEC. They hold their last values in FETCH and IDLE.
- For NOP, JMP, JZ, OUT, HALT, `le` stays 0.
- `run` falling mid-instruction: the current instruction completes, then the FSM enters IDLE. It never aborts between FETCH and EXEC.
- `imem_valid` outside FETCH is ignored.

## Timing
- Zero-wait memory (`imem_valid` in the first FETCH cycle): 3 cycles per instruction (FETCH, DECODE, EXEC). Each wait cycle adds 1.
- `le` and `out_le` are high for exactly one cycle per instruction. The register file writes on the rising edge that ends EXEC.
- Reset: state IDLE, pc=`PC_RESET`, IR=0, `instr_cnt`=0. Every other output is 0. This applies immediately and asynchronously, including mid-instruction.
- Outputs are functions of registered state only; there is no combinational path from `imem_rdata` to any output.

## Configuration
- `CTRL_INSTR_CNT_EN` defined:
  - `instr_cnt` increments on every EXEC exit edge, including HALT.
  - It saturates at 16'hFFFF.
  - TRAP does not count.
- `CTRL_INSTR_CNT_EN` undefined: `instr_cnt` is tied to 16'h0000 and no counter flops are built.

## Test plan
1. Reset, `run`=1, zero-wait memory with program [0x6305 LDI r3,5; 0x6407 LDI r4,7; 0x2534 ADD r5,r3,r4; 0xF000] -> expected:
   - `le` pulses at cycles 3, 6, 9 with `select`=3, 4, 5.
   - Third instruction: `sba`=3, `sbb`=4, `alu_op`=1.
   - `halted`=1 after cycle 12, pc=3.
   - `instr_cnt`=4 with the macro defined.
2. Memory inserts 2 wait cycles per fetch -> 5 cycles per instruction; `imem_req` high throughout FETCH; `imem_addr` stable.
3. 0xA020 JZ 0x20: with `zero`=1 -> pc=0x20; with `zero`=0 -> pc+1. JMP 0x00 at pc=0xFF -> pc=0x00; NOP at pc=0xFF -> pc=0x00.
4. Opcode 0xC at pc=0x04 -> `err`=1, pc stays 0x04, `le` never pulses, `imem_req`=0, state held until `rst_n`=0.
5. `run` dropped during DECODE of 0x8100 OUT -> `out_le` pulses once, FSM enters IDLE, `imem_req`=0. Raising `run` resumes at pc+1.
6. `rst_n` asserted low during EXEC of ADD -> `le` falls immediately, pc=`PC_RESET`, all outputs 0; the write does not occur.

Source files
------------

// File: rtl/control_unit_if.sv
// Instruction-memory fetch bus between the sequencer and instruction memory.
interface control_unit_if;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid;
    logic [15:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_valid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_valid, imem_rdata);
endinterface

// File: rtl/control_unit.sv
// Instruction sequencer for the 8-bit processor: fetch, decode, execute, PC and halt/trap.
// Optional retired-instruction counter is built only when CTRL_INSTR_CNT_EN is defined.
//
// state   | meaning
// IDLE    | waiting for run
// FETCH   | imem_req high, waiting for imem_valid
// DECODE  | IR-derived controls presented, no write
// EXEC    | write/out pulse, PC updated on exit edge
// HALT_ST | HALT executed, held until reset
// TRAP    | illegal opcode, PC frozen, held until reset
module control_unit #(
    parameter logic [7:0] PC_RESET = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    control_unit_if.master        imem,
    input  logic                  zero,
    output logic [3:0]            select,
    output logic                  le,
    output logic [3:0]            sba,
    output logic [3:0]            sbb,
    output logic [2:0]            alu_op,
    output logic [1:0]            src_sel,
    output logic [7:0]            xh,
    output logic                  out_le,
    output logic [7:0]            pc,
    output logic                  halted,
    output logic                  err,
    output logic [15:0]           instr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT,
        S_TRAP
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MOV  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_IN   = 4'h7;
    localparam logic [3:0] OP_OUT  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_ir;
    logic [15:0] w_ir_next;
    logic [7:0]  r_pc;
    logic [7:0]  w_pc_next;
    logic [3:0]  w_op;
    logic        w_is_write;
    logic        w_illegal;

    assign w_op       = r_ir[15:12];
    assign w_is_write = (w_op >= OP_MOV) && (w_op <= OP_IN);
    assign w_illegal  = (w_op > OP_JZ) && (w_op != OP_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ir    <= 16'h0000;
            r_pc    <= PC_RESET;
        end else begin
            r_state <= w_next;
            r_ir    <= w_ir_next;
            r_pc    <= w_pc_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_ir_next = r_ir;
        w_pc_next = r_pc;
        case (r_state)
            S_IDLE: begin
                if (run) w_next = S_FETCH;
            end
            S_FETCH: begin
                if (imem.imem_valid) begin
                    w_ir_next = imem.imem_rdata;
                    w_next    = S_DECODE;
                end
            end
            S_DECODE: begin
                w_next = w_illegal ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                case (w_op)
                    OP_JMP:  w_pc_next = r_ir[7:0];
                    OP_JZ:   w_pc_next = zero ? r_ir[7:0] : r_pc + 8'd1;
                    OP_HALT: w_pc_next = r_pc;
                    default: w_pc_next = r_pc + 8'd1;
                endcase
                if (w_op == OP_HALT) w_next = S_HALT;
                else if (run)        w_next = S_FETCH;
                else                 w_next = S_IDLE;
            end
            S_HALT:  w_next = S_HALT;
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath controls come straight from IR, so they hold through FETCH/IDLE.
    always_comb begin
        alu_op  = 3'd0;
        src_sel = 2'd0;
        case (w_op)
            OP_ADD:  alu_op  = 3'd1;
            OP_SUB:  alu_op  = 3'd2;
            OP_AND:  alu_op  = 3'd3;
            OP_OR:   alu_op  = 3'd4;
            OP_LDI:  src_sel = 2'd1;
            OP_IN:   src_sel = 2'd2;
            default: begin
                alu_op  = 3'd0;
                src_sel = 2'd0;
            end
        endcase
    end

    assign select         = r_ir[11:8];
    assign sba            = r_ir[7:4];
    assign sbb            = r_ir[3:0];
    assign xh             = r_ir[7:0];
    assign le             = (r_state == S_EXEC) && w_is_write;
    assign out_le         = (r_state == S_EXEC) && (w_op == OP_OUT);
    assign imem.imem_req  = (r_state == S_FETCH);
    assign imem.imem_addr = r_pc;
    assign pc             = r_pc;
    assign halted         = (r_state == S_HALT);
    assign err            = (r_state == S_TRAP);

`ifdef CTRL_INSTR_CNT_EN
    logic [15:0] r_instr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_cnt <= 16'h0000;
        end else if ((r_state == S_EXEC) && (r_instr_cnt != 16'hFFFF)) begin
            r_instr_cnt <= r_instr_cnt + 16'd1;
        end
    end

    assign instr_cnt = r_instr_cnt;
`else
    assign instr_cnt = 16'h0000;
`endif

endmodule
